pe_uno_seq: RTL
===============

// Module: pe_uno_seq
// PURPOSE
//   Sequencer for a column of RAVEN PEs. Drives the shared gemm_uno mode select and the weight/coefficient
//   (wc) input that the PE column needs for unary ops (div/exp/log).
//   Horner evaluation: the PE column computes o <= o*x + c, with one coefficient per cycle, highest index first.
//   Each coefficient comes from an internal per-op coefficient table.
//   Sits between the array command front-end and the PE column's wc_i / gemm_uno inputs.
// PARAMETERS
//   MUL_BW     16  coefficient width; matches the PE wc_i width.
//   MAX_TERMS   8  coefficient table depth per op. Must be a power of 2, >= 2.
//   DRAIN_LAT   2  cycles the PE pipeline needs after the last coefficient. 0 is legal.
//   localparam IDX_BW = $clog2(MAX_TERMS); TRM_BW = IDX_BW+1
// PORTS
//   clk        in   1       clock
//   rst        in   1       synchronous reset, active high
//   cmd_valid  in   1       command request
//   cmd_ready  out  1       high only in IDLE
//   cmd_op     in   2       00 gemm, 01 div, 10 exp, 11 log
//   cmd_terms  in   TRM_BW  coefficient count for uno ops; ignored for gemm
//   cfg_we     in   1       coefficient table write enable
//   cfg_op     in   2       table select (01/10/11; 00 ignored)
//   cfg_idx    in   IDX_BW  coefficient index
//   cfg_data   in   MUL_BW  signed coefficient
//   gemm_uno   out  2       PE mode select
//   wc_o       out  MUL_BW  coefficient to PE wc_i
//   wc_vld     out  1       wc_o carries a coefficient this cycle
//   busy       out  1       command in progress
//   done       out  1       one-cycle completion pulse
//   err        out  1       one-cycle illegal-command pulse
// BEHAVIOUR
//   Reset: state IDLE; gemm_uno=00, wc_o=0, wc_vld=0, busy=0, done=0, err=0, cmd_ready=1. Tables cleared to 0.
//   All outputs are registered. Handshake happens on cmd_valid&cmd_ready; it is only possible in IDLE.
//   FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//     IDLE: gemm_uno holds the last op value. 00 after reset.
//   Gemm cmd (op=00), accepted at cycle 0:
//     cycle 1: gemm_uno=00, done=1 (DONE state). Cycle 2: IDLE.
//   Uno cmd (op!=00) with 1<=terms<=MAX_TERMS, accepted at cycle 0:
//     ISSUE at cycles 1..terms: gemm_uno=op, wc_vld=1, wc_o = tbl[op][terms-k] at cycle k (descending index).
//     DRAIN at cycles terms+1..terms+DRAIN_LAT: wc_vld=0, wc_o=0, gemm_uno=op. Skipped when DRAIN_LAT=0.
//     DONE at cycle terms+DRAIN_LAT+1: done=1. IDLE at the next cycle. gemm_uno keeps op.
//   busy=1 from cycle 1 through the DONE cycle inclusive.
//   Illegal uno cmd (terms=0 or terms>MAX_TERMS): handshake completes. err=1 next cycle; state stays IDLE.
//     gemm_uno is unchanged and done is not pulsed.
//   Table write: tbl[cfg_op][cfg_idx] <= cfg_data on cfg_we when cfg_op!=00.
//     A write to the op currently in ISSUE is dropped. Writes to other ops proceed.
//     A write and a read of the same entry in the same cycle (when not active) returns the old data.
//   Counters: down-counter for the term index, separate counter for DRAIN. No wrap: both terminate at 0.
//   rst mid-operation: returns to IDLE next cycle, with all reset values. No done pulse. Tables cleared.
//   cmd_valid while busy: ignored (cmd_ready=0), no side effects.
// CONFIGURATION
//   Macro PE_UNO_SEQ_PERF_EN.
//   Defined: extra ports perf_clr (in, 1) and perf_busy_cnt (out, 32).
//     perf_busy_cnt increments on every cycle busy=1 and saturates at 2^32-1.
//     Cleared by rst, or by perf_clr (clear wins over increment).
//   Undefined: no ports, no counter logic. Functional behaviour is identical.
// TESTING
//   1. Write tbl[10][0..3]=1,2,3,4; cmd op=10, terms=4 at cycle 0.
//      -> wc_o=4,3,2,1 at cycles 1-4 with wc_vld=1; done at cycle 7; busy for cycles 1-7.
//   2. cmd op=00 -> gemm_uno=00 and done=1 at cycle 1, cmd_ready=1 at cycle 2. No wc_vld.
//   3. cmd op=01, terms=0, then terms=9 -> err pulse each time. No done; gemm_uno unchanged.
//   4. During op=11 ISSUE: write tbl[11][0]=7 and tbl[01][0]=5.
//      -> the 11 write is dropped (readback via a new cmd shows the old value); the 01 write takes effect.
//   5. Assert rst at cycle 2 of a terms=8 cmd -> next cycle IDLE, all outputs at reset values, no done.
//      A new cmd is accepted immediately.
//   6. DRAIN_LAT=0 build, terms=1 -> wc_vld at cycle 1, done at cycle 2.
//      Back-to-back cmds are accepted every 3 cycles.

Source files
------------

// File: rtl/pe_uno_seq.sv
// Sequencer that feeds Horner coefficients and the gemm/uno mode select to a column of RAVEN PEs.
// Latency: gemm done 1 cycle after accept; uno done terms+DRAIN_LAT+1 cycles after accept.
// Backpressure: cmd_ready is high only in IDLE; optional busy-cycle counter under PE_UNO_SEQ_PERF_EN.
module pe_uno_seq #(
  parameter int MUL_BW    = 16,
  parameter int MAX_TERMS = 8,
  parameter int DRAIN_LAT = 2,
  localparam int IDX_BW   = $clog2(MAX_TERMS),
  localparam int TRM_BW   = IDX_BW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [TRM_BW-1:0] cmd_terms,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_op,
  input  logic [IDX_BW-1:0] cfg_idx,
  input  logic [MUL_BW-1:0] cfg_data,
  output logic [1:0]        gemm_uno,
  output logic [MUL_BW-1:0] wc_o,
  output logic              wc_vld,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef PE_UNO_SEQ_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_busy_cnt
`endif
);

  // Drain counter holds DRAIN_LAT-1 down to 0; keep at least one bit so DRAIN_LAT=0 still elaborates.
  localparam int DRN_BW = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
  localparam logic [DRN_BW-1:0] DRN_INIT = DRN_BW'((DRAIN_LAT > 0) ? DRAIN_LAT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [IDX_BW-1:0]   idx_q, idx_d;
  logic [DRN_BW-1:0]   drn_q, drn_d;
  logic [1:0]          gemm_d;
  logic [MUL_BW-1:0]   wc_d;
  logic                vld_d, done_d, err_d;
  logic                terms_ok;
  logic                tbl_wr;

  // Row 0 (gemm) exists only to keep indexing direct by op code; it is never written.
  logic [MUL_BW-1:0]   tbl [4][MAX_TERMS];

  assign terms_ok = (cmd_terms != '0) && (cmd_terms <= TRM_BW'(MAX_TERMS));
  // Writes into the table being streamed would corrupt the in-flight evaluation, so they are dropped.
  assign tbl_wr   = cfg_we && (cfg_op != 2'b00) && !((state_q == S_ISSUE) && (cfg_op == op_q));

  // Coefficient table: cleared on reset, written from the config port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 4; o++)
        for (int i = 0; i < MAX_TERMS; i++)
          tbl[o][i] <= '0;
    end else if (tbl_wr) begin
      tbl[cfg_op][cfg_idx] <= cfg_data;
    end
  end

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    drn_d   = drn_q;
    gemm_d  = gemm_uno;
    wc_d    = '0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_op == 2'b00) begin
            state_d = S_DONE;
            op_d    = 2'b00;
            gemm_d  = 2'b00;
            done_d  = 1'b1;
          end else if (terms_ok) begin
            state_d = S_ISSUE;
            op_d    = cmd_op;
            idx_d   = IDX_BW'(cmd_terms - TRM_BW'(1));
            gemm_d  = cmd_op;
            vld_d   = 1'b1;
            wc_d    = tbl[cmd_op][idx_d];
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (idx_q == '0) begin
          if (DRAIN_LAT > 0) begin
            state_d = S_DRAIN;
            drn_d   = DRN_INIT;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          idx_d = idx_q - IDX_BW'(1);
          vld_d = 1'b1;
          wc_d  = tbl[op_q][idx_d];
        end
      end
      S_DRAIN: begin
        if (drn_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drn_d = drn_q - DRN_BW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      idx_q     <= '0;
      drn_q     <= '0;
      gemm_uno  <= 2'b00;
      wc_o      <= '0;
      wc_vld    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      drn_q     <= drn_d;
      gemm_uno  <= gemm_d;
      wc_o      <= wc_d;
      wc_vld    <= vld_d;
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
      err       <= err_d;
      cmd_ready <= (state_d == S_IDLE);
    end
  end

`ifdef PE_UNO_SEQ_PERF_EN
  // Saturating count of busy cycles; clear takes priority over increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      perf_busy_cnt <= '0;
    end else if (busy && (perf_busy_cnt != '1)) begin
      perf_busy_cnt <= perf_busy_cnt + 32'd1;
    end
  end
`endif

endmodule
